// File: rtl/dest_hazard_scoreboard_pkg.sv
// Shared types and constants for the destination-register hazard scoreboard.
// An entry describes one in-flight instruction's pending register write.
package dest_hazard_scoreboard_pkg;

    localparam int REG_W    = 3;
    localparam int NUM_REGS = 8;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             ld;
    } sb_entry_t;

endpackage

// File: rtl/dest_hazard_scoreboard_sb_match.sv
// Compares one source register against the tracked in-flight destinations.
// Stages at or beyond LIM are ignored; with FWD only a load sitting in EX can hit.
module sb_match
    import dest_hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int LIM   = 2,
    parameter int FWD   = 0
) (
    input  sb_entry_t [DEPTH-1:0] stages_i,
    input  logic [REG_W-1:0]      src_i,
    output logic                  hit_o
);

    always_comb begin
        hit_o = 1'b0;
        if (FWD != 0) begin
            hit_o = stages_i[STG_EX].v & stages_i[STG_EX].ld & (stages_i[STG_EX].rd == src_i);
        end else begin
            for (int i = 0; i < LIM; i++) begin
                if (stages_i[i].v && (stages_i[i].rd == src_i)) begin
                    hit_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dest_hazard_scoreboard.sv
// Tracks decoded destination registers through EX..WB and raises a zero-latency
// stall when the decoding instruction reads a register still pending a write.
module dest_hazard_scoreboard
    import dest_hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int RF_BYPASS = 1,
    parameter int FWD       = 0,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 id_wr_en,
    input  logic [REG_W-1:0]     id_rd,
    input  logic                 id_is_load,
    input  logic [REG_W-1:0]     id_rs,
    input  logic                 id_rs_used,
    input  logic [REG_W-1:0]     id_rt,
    input  logic                 id_rt_used,
    input  logic                 flush,
    output logic                 stall,
    output logic [NUM_REGS-1:0]  busy_mask,
    output logic [CNT_W-1:0]     stall_count
);

    // With a write-through register file the WB entry is already visible to decode.
    localparam int LIM = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;

    sb_entry_t [DEPTH-1:0] stg_q, stg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rs_hit, rt_hit;

    sb_match #(.DEPTH(DEPTH), .LIM(LIM), .FWD(FWD)) u_rs_match (
        .stages_i (stg_q),
        .src_i    (id_rs),
        .hit_o    (rs_hit)
    );

    sb_match #(.DEPTH(DEPTH), .LIM(LIM), .FWD(FWD)) u_rt_match (
        .stages_i (stg_q),
        .src_i    (id_rt),
        .hit_o    (rt_hit)
    );

    // Decode hands an instruction to EX on an edge where id_valid & ~stall & ~flush;
    // otherwise a bubble enters EX and decode must hold the same instruction.
    assign stall = id_valid & ((id_rs_used & rs_hit) | (id_rt_used & rt_hit)) & ~flush;

    always_comb begin
        stg_d = stg_q;
        for (int i = 1; i < DEPTH; i++) begin
            stg_d[i] = stg_q[i-1];
            // A redirect kills everything younger than the instruction now entering WB.
            if (flush && (i < DEPTH - 1)) begin
                stg_d[i].v = 1'b0;
            end
        end
        if (flush || stall) begin
            stg_d[0] = '0;
        end else begin
            stg_d[0].v  = id_valid & id_wr_en;
            stg_d[0].rd = id_rd;
            stg_d[0].ld = id_is_load & id_wr_en;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stg_q[i].v) begin
                busy_mask[stg_q[i].rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_q <= '0;
            cnt_q <= '0;
        end else begin
            stg_q <= stg_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule
